// File: rtl/tlbelo_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tlbelo_csr_bank
// Brief    : Bank of LoongArch32 TLBELO CSRs with masked CSR writes, TLBRD
//            load/clear, registered CSR read and TLB write-path field outputs.
// Revision : 1.0
// ============================================================================
module tlbelo_csr_bank #(
    parameter int          N_ELO    = 2,
    parameter int          PALEN    = 32,
    parameter logic [13:0] CSR_BASE = 14'h12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          csr_re,
    input  logic                          csr_we,
    input  logic [13:0]                   csr_addr,
    input  logic [31:0]                   csr_wdata,
    input  logic [31:0]                   csr_wmask,
    output logic [31:0]                   csr_rdata,
    output logic                          csr_rvalid,
    input  logic                          tlbrd_en,
    input  logic                          tlbrd_e,
    input  logic [N_ELO*(PALEN-12)-1:0]   tlbrd_ppn,
    input  logic [N_ELO*6-1:0]            tlbrd_flags,
    input  logic                          tlbrd_g,
    output logic [N_ELO*(PALEN-12)-1:0]   elo_ppn,
    output logic [N_ELO*6-1:0]            elo_flags,
    output logic                          elo_g
);

    localparam int          c_PPN_W    = PALEN - 12;
    localparam logic [63:0] c_PPN_ONES = (64'd1 << c_PPN_W) - 64'd1;
    // V, D, PLV, MAT, G and the PPN field; bit 7 and bits above PPN stay zero
    localparam logic [31:0] c_WRITABLE = 32'h0000_007F | 32'(c_PPN_ONES << 8);

    logic [N_ELO-1:0][31:0] r_elo;
    logic [31:0]            r_rdata;
    logic                   r_rvalid;

    logic [N_ELO-1:0]       w_hit;
    logic [N_ELO-1:0][31:0] w_tlbrd_val;
    logic [N_ELO-1:0]       w_g;
    logic [31:0]            w_rd_mux;
    logic [31:0]            w_wmask;

    always_comb begin
        w_wmask  = csr_wmask & c_WRITABLE;
        w_rd_mux = '0;
        for (int k = 0; k < N_ELO; k++) begin
            w_hit[k]       = (csr_addr == CSR_BASE + 14'(k));
            w_tlbrd_val[k] = 32'({tlbrd_ppn[k*c_PPN_W +: c_PPN_W], 1'b0, tlbrd_g,
                                  tlbrd_flags[k*6 +: 6]});
            if (w_hit[k]) begin
                w_rd_mux = r_elo[k];
            end
        end
    end

    // TLBRD outranks a same-cycle CSR write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_elo <= '0;
        end else begin
            for (int k = 0; k < N_ELO; k++) begin
                if (tlbrd_en) begin
                    r_elo[k] <= tlbrd_e ? w_tlbrd_val[k] : 32'h0;
                end else if (csr_we && w_hit[k]) begin
                    r_elo[k] <= (r_elo[k] & ~w_wmask) | (csr_wdata & w_wmask);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= csr_re;
            if (csr_re) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    generate
        for (genvar k = 0; k < N_ELO; k++) begin : g_elo_out
            assign elo_ppn[k*c_PPN_W +: c_PPN_W] = r_elo[k][PALEN-5:8];
            assign elo_flags[k*6 +: 6]           = r_elo[k][5:0];
            assign w_g[k]                        = r_elo[k][6];
        end
    endgenerate

    assign elo_g      = &w_g;
    assign csr_rdata  = r_rdata;
    assign csr_rvalid = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_tlbelo_csr_bank.sv
`default_nettype none
// Testbench for tlbelo_csr_bank: two instances (2 x PALEN 32, 4 x PALEN 36)
// driven by shared directed stimulus and checked against a register-level model.
module tb_tlbelo_csr_bank;

    localparam logic [13:0] BASE = 14'h12;

    logic        clk;
    logic        rst_n;
    logic        csr_re, csr_we;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata, csr_wmask;
    logic        tlbrd_en, tlbrd_e, tlbrd_g;
    logic [23:0] s_ppn   [4];
    logic [5:0]  s_flags [4];

    logic [39:0] ppn_a;   logic [11:0] flags_a;
    logic [95:0] ppn_b;   logic [23:0] flags_b;

    logic [31:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, g_a, g_b;
    logic [39:0] eppn_a;  logic [11:0] eflags_a;
    logic [95:0] eppn_b;  logic [23:0] eflags_b;

    int total = 0;
    int bad   = 0;

    always_comb begin
        ppn_a = '0; flags_a = '0; ppn_b = '0; flags_b = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < 2) begin
                ppn_a[k*20 +: 20] = s_ppn[k][19:0];
                flags_a[k*6 +: 6] = s_flags[k];
            end
            ppn_b[k*24 +: 24] = s_ppn[k];
            flags_b[k*6 +: 6] = s_flags[k];
        end
    end

    tlbelo_csr_bank #(.N_ELO(2), .PALEN(32), .CSR_BASE(BASE)) dut_a (
        .clk(clk), .rst_n(rst_n), .csr_re(csr_re), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .csr_rdata(rdata_a), .csr_rvalid(rvalid_a),
        .tlbrd_en(tlbrd_en), .tlbrd_e(tlbrd_e), .tlbrd_ppn(ppn_a), .tlbrd_flags(flags_a),
        .tlbrd_g(tlbrd_g), .elo_ppn(eppn_a), .elo_flags(eflags_a), .elo_g(g_a)
    );

    tlbelo_csr_bank #(.N_ELO(4), .PALEN(36), .CSR_BASE(BASE)) dut_b (
        .clk(clk), .rst_n(rst_n), .csr_re(csr_re), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .csr_rdata(rdata_b), .csr_rvalid(rvalid_b),
        .tlbrd_en(tlbrd_en), .tlbrd_e(tlbrd_e), .tlbrd_ppn(ppn_b), .tlbrd_flags(flags_b),
        .tlbrd_g(tlbrd_g), .elo_ppn(eppn_b), .elo_flags(eflags_b), .elo_g(g_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: index 0 = instance a (2 regs, 20-bit PPN), 1 = instance b (4 regs, 24-bit PPN)
    logic [31:0] mdl [2][4];
    logic [31:0] exp_rd [2];
    logic        exp_rv [2];
    logic        started = 1'b0;
    int          m_n, m_pw, m_off;
    logic [31:0] m_wr, m_pmask;

    logic [39:0] x_ppn_a;  logic [11:0] x_fl_a;
    logic [95:0] x_ppn_b;  logic [23:0] x_fl_b;

    always @(posedge clk) begin
        if (!rst_n) begin
            started = 1'b1;
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 4; k++) mdl[i][k] = 32'h0;
                exp_rd[i] = 32'h0;
                exp_rv[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_n     = (i == 0) ? 2 : 4;
                m_pw    = (i == 0) ? 20 : 24;
                m_off   = int'(csr_addr) - int'(BASE);
                m_pmask = (32'h1 << m_pw) - 32'h1;
                m_wr    = 32'h7F | (m_pmask << 8);
                exp_rv[i] = csr_re;
                if (csr_re) exp_rd[i] = (m_off >= 0 && m_off < m_n) ? mdl[i][m_off] : 32'h0;
                if (tlbrd_en) begin
                    for (int k = 0; k < m_n; k++)
                        mdl[i][k] = tlbrd_e ? ((({8'h0, s_ppn[k]} & m_pmask) << 8)
                                               | {25'h0, tlbrd_g, s_flags[k]}) : 32'h0;
                end else if (csr_we && m_off >= 0 && m_off < m_n) begin
                    mdl[i][m_off] = (mdl[i][m_off] & ~(csr_wmask & m_wr))
                                  | (csr_wdata & csr_wmask & m_wr);
                end
            end
        end
        if (started) begin
            #1;
            x_ppn_a = '0; x_fl_a = '0; x_ppn_b = '0; x_fl_b = '0;
            for (int k = 0; k < 4; k++) begin
                if (k < 2) begin
                    x_ppn_a[k*20 +: 20] = mdl[0][k][27:8];
                    x_fl_a[k*6 +: 6]    = mdl[0][k][5:0];
                end
                x_ppn_b[k*24 +: 24] = mdl[1][k][31:8];
                x_fl_b[k*6 +: 6]    = mdl[1][k][5:0];
            end
            chk("a_rdata",  128'(rdata_a),  128'(exp_rd[0]));
            chk("a_rvalid", 128'(rvalid_a), 128'(exp_rv[0]));
            chk("a_ppn",    128'(eppn_a),   128'(x_ppn_a));
            chk("a_flags",  128'(eflags_a), 128'(x_fl_a));
            chk("a_g",      128'(g_a),      128'(mdl[0][0][6] & mdl[0][1][6]));
            chk("b_rdata",  128'(rdata_b),  128'(exp_rd[1]));
            chk("b_rvalid", 128'(rvalid_b), 128'(exp_rv[1]));
            chk("b_ppn",    128'(eppn_b),   128'(x_ppn_b));
            chk("b_flags",  128'(eflags_b), 128'(x_fl_b));
            chk("b_g",      128'(g_b),      128'(mdl[1][0][6] & mdl[1][1][6]
                                                 & mdl[1][2][6] & mdl[1][3][6]));
        end
    end

    task automatic idle();
        csr_re = 1'b0; csr_we = 1'b0; tlbrd_en = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a);
        idle(); csr_re = 1'b1; csr_addr = a;
        @(negedge clk);
    endtask

    initial begin
        idle();
        tlbrd_e = 1'b0; tlbrd_g = 1'b0;
        for (int k = 0; k < 4; k++) begin s_ppn[k] = '0; s_flags[k] = '0; end
        rst_n = 1'b0; csr_we = 1'b1; csr_addr = BASE;
        csr_wdata = 32'hFFFF_FFFF; csr_wmask = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        rd(BASE);
        chk("L_rst_rdata",  128'(rdata_a),  128'(32'h0));
        chk("L_rst_rvalid", 128'(rvalid_a), 128'(1'b1));

        idle(); csr_we = 1'b1; csr_addr = BASE + 14'd1;
        csr_wdata = 32'hFFFF_FFFF; csr_wmask = 32'h0000_00F0;
        @(negedge clk);
        rd(BASE + 14'd1);
        chk("L_mask_a", 128'(rdata_a), 128'(32'h0000_0070));
        chk("L_mask_b", 128'(rdata_b), 128'(32'h0000_0070));

        idle(); tlbrd_en = 1'b1; tlbrd_e = 1'b1; tlbrd_g = 1'b1;
        s_ppn[0] = 24'h012345; s_ppn[1] = 24'h00ABCD; s_ppn[2] = 24'h055AA5; s_ppn[3] = 24'hFEDCBA;
        s_flags[0] = 6'h3F; s_flags[1] = 6'h2A; s_flags[2] = 6'h15; s_flags[3] = 6'h0C;
        @(negedge clk);
        rd(BASE);
        chk("L_tlbrd_r0", 128'(rdata_a), 128'(32'h0123_457F));
        chk("L_tlbrd_g",  128'(g_a),     128'(1'b1));
        rd(BASE + 14'd1);
        chk("L_tlbrd_r1", 128'(rdata_a), 128'(32'h00AB_CD6A));
        rd(BASE + 14'd3);
        chk("L_tlbrd_b3", 128'(rdata_b), 128'(32'hFEDC_BA4C));

        idle(); csr_we = 1'b1; csr_addr = BASE + 14'd1;
        csr_wdata = 32'h0; csr_wmask = 32'h0000_0040;
        @(negedge clk);
        chk("L_gand_a", 128'(g_a), 128'(1'b0));
        chk("L_gand_b", 128'(g_b), 128'(1'b0));

        idle(); tlbrd_en = 1'b1; tlbrd_e = 1'b0;
        @(negedge clk);
        chk("L_clr_flags", 128'(eflags_a), 128'(12'h0));
        chk("L_clr_ppn",   128'(eppn_b),   128'(96'h0));

        idle(); tlbrd_en = 1'b1; tlbrd_e = 1'b1; tlbrd_g = 1'b0; s_flags[0] = 6'h3E;
        csr_we = 1'b1; csr_addr = BASE; csr_wdata = 32'h0000_0001; csr_wmask = 32'hFFFF_FFFF;
        @(negedge clk);
        rd(BASE);
        chk("L_same_cyc", 128'(rdata_a), 128'(32'h0123_453E));

        idle(); csr_re = 1'b1; csr_we = 1'b1; csr_addr = BASE;
        csr_wdata = 32'h0000_0103; csr_wmask = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("L_raw_old", 128'(rdata_b), 128'(32'h0123_453E));
        rd(BASE);
        chk("L_raw_new", 128'(rdata_b), 128'(32'h0000_0103));

        idle(); csr_we = 1'b1; csr_addr = BASE; csr_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rd(BASE);
        chk("L_ppnw_a", 128'(rdata_a), 128'(32'h0FFF_FF7F));
        chk("L_ppnw_b", 128'(rdata_b), 128'(32'hFFFF_FF7F));

        rd(BASE + 14'd4);
        chk("L_unmap_rd", 128'(rdata_b),  128'(32'h0));
        chk("L_unmap_rv", 128'(rvalid_b), 128'(1'b1));
        rd(BASE - 14'd1);
        idle();
        @(negedge clk);
        chk("L_norv", 128'(rvalid_a), 128'(1'b0));

        for (int c = 0; c < 80; c++) begin
            csr_re    = 1'($urandom_range(0, 1));
            csr_we    = 1'($urandom_range(0, 1));
            tlbrd_en  = ($urandom_range(0, 7) == 0);
            tlbrd_e   = 1'($urandom_range(0, 1));
            tlbrd_g   = ($urandom_range(0, 3) != 0);
            csr_addr  = BASE - 14'd1 + 14'($urandom_range(0, 5));
            csr_wdata = $urandom;
            csr_wmask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            for (int k = 0; k < 4; k++) begin
                s_ppn[k]   = 24'($urandom);
                s_flags[k] = 6'($urandom);
            end
            rst_n = (c != 40);
            @(negedge clk);
        end
        idle(); rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
